// File: rtl/spi_sram_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_sram_seq
// Description : SPI mode-0 serial SRAM slave with byte / page / sequential
//               burst modes selected by a status register. All SPI pins are
//               oversampled on clk; clk must run at >= 8x the sck rate.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   csb    in  chip select, active low
//   sck    in  SPI clock (mode 0: sample on rise, shift on fall)
//   si     in  serial data in
//   holdb  in  hold, active low (only honoured with SPI_SRAM_HOLD_EN)
//   so     out serial data out, meaningful only while so_oe=1
//   so_oe  out output enable for the so pad driver
// Build option:
//   SPI_SRAM_HOLD_EN  when defined, holdb=0 with sck low pauses the device
// ============================================================================
module spi_sram_seq #(
  parameter int ADDR_W     = 16,
  parameter int MEM_AW     = 13,
  parameter int PAGE_BYTES = 32,
  parameter int SYNC_STG   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic csb,
  input  logic sck,
  input  logic si,
  input  logic holdb,
  output logic so,
  output logic so_oe
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CMD    = 3'd1;
  localparam logic [2:0] c_ST_ADDR   = 3'd2;
  localparam logic [2:0] c_ST_WDATA  = 3'd3;
  localparam logic [2:0] c_ST_RDATA  = 3'd4;
  localparam logic [2:0] c_ST_RDSR   = 3'd5;
  localparam logic [2:0] c_ST_WRSR   = 3'd6;
  localparam logic [2:0] c_ST_IGNORE = 3'd7;

  localparam int c_CNT_W = $clog2(ADDR_W);
  // The top shifted bit is never needed: the last bit of a word is taken
  // straight from si when the word completes.
  localparam int c_SH_W  = ((MEM_AW > 8) ? MEM_AW : 8) - 1;
  localparam logic [c_CNT_W-1:0] c_CNT_BYTE = c_CNT_W'(7);
  localparam logic [c_CNT_W-1:0] c_CNT_ADDR = c_CNT_W'(ADDR_W - 1);
  localparam logic [MEM_AW-1:0]  c_PG_MASK  = MEM_AW'(PAGE_BYTES - 1);
  localparam logic [MEM_AW-1:0]  c_PTR_ONE  = MEM_AW'(1);

`ifdef SPI_SRAM_HOLD_EN
  localparam logic c_HOLD_EN = 1'b1;
`else
  localparam logic c_HOLD_EN = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // --------------------------------------------------------------------------
  logic [SYNC_STG-1:0] r_csb_sync, r_sck_sync, r_si_sync, r_holdb_sync;
  logic                r_sck_d, r_csb_d, r_hold;
  logic                w_csb_s, w_sck_s, w_si_s, w_holdb_s, w_hold;
  logic                w_sck_rise, w_sck_fall, w_csb_fall;

  // csb chain and its delayed copy reset low: a csb falling edge is then only
  // seen after csb has really been high, so a command after reset always
  // needs a fresh high->low transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_csb_sync   <= '0;
      r_sck_sync   <= '0;
      r_si_sync    <= '0;
      r_holdb_sync <= '1;
      r_sck_d      <= 1'b0;
      r_csb_d      <= 1'b0;
    end else begin
      r_csb_sync   <= {r_csb_sync[SYNC_STG-2:0], csb};
      r_sck_sync   <= {r_sck_sync[SYNC_STG-2:0], sck};
      r_si_sync    <= {r_si_sync[SYNC_STG-2:0], si};
      r_holdb_sync <= {r_holdb_sync[SYNC_STG-2:0], holdb};
      r_sck_d      <= w_sck_s;
      r_csb_d      <= w_csb_s;
    end
  end

  assign w_csb_s   = r_csb_sync[SYNC_STG-1];
  assign w_sck_s   = r_sck_sync[SYNC_STG-1];
  assign w_si_s    = r_si_sync[SYNC_STG-1];
  assign w_holdb_s = r_holdb_sync[SYNC_STG-1];

  // Hold is entered only while sck is low and released as soon as holdb rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= 1'b0;
    end else if (w_csb_s || w_holdb_s) begin
      r_hold <= 1'b0;
    end else if (!w_sck_s) begin
      r_hold <= 1'b1;
    end
  end

  assign w_hold     = c_HOLD_EN & r_hold;
  assign w_sck_rise =  w_sck_s & ~r_sck_d & ~w_hold;
  assign w_sck_fall = ~w_sck_s &  r_sck_d & ~w_hold;
  assign w_csb_fall = ~w_csb_s &  r_csb_d;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]         r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_bitcnt;
  logic [c_SH_W-1:0]  r_shift;
  logic [MEM_AW-1:0]  r_ptr, w_ptr_adv;
  logic [7:0]         r_osh, r_rd_data, w_rd_src, w_byte_in;
  logic [2:0]         r_obit;
  logic [1:0]         r_status;
  logic               r_so, r_oe, r_done, r_is_read, w_we;
  logic [MEM_AW-1:0]  w_addr_in;
  logic [7:0]         r_mem [2**MEM_AW];

  assign w_byte_in = {r_shift[6:0], w_si_s};
  assign w_addr_in = {r_shift[MEM_AW-2:0], w_si_s};

  // Page mode wraps inside the aligned page; otherwise wrap over the array.
  assign w_ptr_adv = (r_status == 2'b10)
                   ? ((r_ptr & ~c_PG_MASK) | ((r_ptr + c_PTR_ONE) & c_PG_MASK))
                   : (r_ptr + c_PTR_ONE);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_csb_s) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: if (w_csb_fall) w_state_nxt = c_ST_CMD;
        c_ST_CMD: begin
          if (w_sck_rise && (r_bitcnt == c_CNT_BYTE)) begin
            case (w_byte_in)
              8'h03, 8'h02: w_state_nxt = c_ST_ADDR;
              8'h05:        w_state_nxt = c_ST_RDSR;
              8'h01:        w_state_nxt = c_ST_WRSR;
              default:      w_state_nxt = c_ST_IGNORE;
            endcase
          end
        end
        c_ST_ADDR: begin
          if (w_sck_rise && (r_bitcnt == c_CNT_ADDR)) begin
            w_state_nxt = r_is_read ? c_ST_RDATA : c_ST_WDATA;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_we     = (r_state == c_ST_WDATA) && w_sck_rise && (r_bitcnt == c_CNT_BYTE)
               && !r_done && !w_csb_s;
    w_rd_src = (r_state == c_ST_RDSR) ? {r_status, 6'b0} : r_rd_data;
    so_oe    = r_oe & ~w_hold & ~w_csb_s;
    so       = r_so;
  end

  // --------------------------------------------------------------------------
  // Shift / count / pointer logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_osh     <= '0;
      r_obit    <= '0;
      r_status  <= 2'b00;
      r_so      <= 1'b0;
      r_oe      <= 1'b0;
      r_done    <= 1'b0;
      r_is_read <= 1'b0;
    end else if (w_csb_s) begin
      r_bitcnt <= '0;
      r_obit   <= '0;
      r_oe     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_sck_rise) begin
        case (r_state)
          c_ST_CMD: begin
            r_shift <= {r_shift[c_SH_W-2:0], w_si_s};
            if (r_bitcnt == c_CNT_BYTE) begin
              r_bitcnt  <= '0;
              r_is_read <= (w_byte_in == 8'h03);
            end else begin
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
          c_ST_ADDR: begin
            r_shift <= {r_shift[c_SH_W-2:0], w_si_s};
            if (r_bitcnt == c_CNT_ADDR) begin
              r_bitcnt <= '0;
              r_ptr    <= w_addr_in;
              r_obit   <= '0;
            end else begin
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
          c_ST_WDATA, c_ST_WRSR: begin
            r_shift <= {r_shift[c_SH_W-2:0], w_si_s};
            if (r_bitcnt == c_CNT_BYTE) begin
              r_bitcnt <= '0;
              if (r_state == c_ST_WRSR) begin
                // 2'b11 is a reserved mode and leaves the status untouched.
                if (w_byte_in[7:6] != 2'b11) r_status <= w_byte_in[7:6];
              end else if (!r_done) begin
                r_ptr <= w_ptr_adv;
                if (r_status == 2'b00) r_done <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
          default: ;
        endcase
      end

      if (w_sck_fall && ((r_state == c_ST_RDATA) || (r_state == c_ST_RDSR))) begin
        if (r_done) begin
          r_oe <= 1'b0;
        end else begin
          r_oe <= 1'b1;
          // Bit 7 of each byte comes straight from the source; the rest
          // follow from the out shifter.
          if (r_obit == 3'd0) begin
            r_so  <= w_rd_src[7];
            r_osh <= {w_rd_src[6:0], 1'b0};
          end else begin
            r_so  <= r_osh[7];
            r_osh <= {r_osh[6:0], 1'b0};
          end
          r_obit <= r_obit + 3'd1;
          if ((r_obit == 3'd7) && (r_state == c_ST_RDATA)) begin
            r_ptr <= w_ptr_adv;
            if (r_status == 2'b00) r_done <= 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: registered read of mem[ptr]. The read data is needed only
  // on the next sck falling edge, which is several clk cycles after any
  // pointer update.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr] <= w_byte_in;
    r_rd_data <= r_mem[r_ptr];
  end

endmodule
`default_nettype wire
